// File: rtl/redmule_tile_evt_ctrl.sv
// Tile event/wake-up consumer: latches event pulses, drives irq vector and wake-from-event pulse.
// Optional per-line event counters are enabled by defining REDMULE_EVT_CNT_EN.
module redmule_tile_evt_ctrl #(
  parameter int unsigned N_CORE       = 1,
  parameter int unsigned N_IRQ        = 32,
  parameter int unsigned EVT_IRQ_BASE = 16,
  parameter int unsigned WAKE_TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [2*N_CORE-1:0]        evt_i,
  input  logic                       core_sleep_i,
  input  logic                       busy_i,
  input  logic [2*N_CORE-1:0]        mask_i,
  input  logic [2*N_CORE-1:0]        clr_i,
  output logic [N_IRQ-1:0]           irq_o,
  output logic                       wu_wfe_o,
  output logic [2*N_CORE-1:0]        pending_o,
`ifdef REDMULE_EVT_CNT_EN
  output logic [2*N_CORE-1:0][15:0]  evt_cnt_o,
`endif
  output logic                       busy_fall_o
);

  localparam int unsigned NumLines = 2 * N_CORE;
  localparam int unsigned TmoW     = (WAKE_TIMEOUT > 1) ? $clog2(WAKE_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(WAKE_TIMEOUT - 1);

  if (EVT_IRQ_BASE + NumLines > N_IRQ) begin : g_bad_irq_map
    $error("event lines do not fit in irq vector");
  end
  if (WAKE_TIMEOUT < 2) begin : g_bad_timeout
    $error("WAKE_TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StArmed, StWake, StWaitAck} state_e;

  state_e                state_q, state_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [NumLines-1:0]   pending_q, pending_d;
  logic                  wu_q, wu_d;
  logic                  busy_q;
  logic                  wake_req;

  // Set wins over clear on the same line.
  assign pending_d = (pending_q & ~clr_i) | evt_i;
  assign wake_req  = |(pending_q & mask_i);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      StIdle: begin
        if (core_sleep_i) state_d = StArmed;
      end
      StArmed: begin
        if (!core_sleep_i) state_d = StIdle;
        else if (wake_req) state_d = StWake;
      end
      StWake: begin
        tmo_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (!core_sleep_i) begin
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          state_d = wake_req ? StWake : StArmed;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wu_d = (state_d == StWake);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      pending_q <= '0;
      wu_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      wu_q      <= wu_d;
      busy_q    <= busy_i;
    end
  end

  always_comb begin
    irq_o = '0;
    irq_o[EVT_IRQ_BASE +: NumLines] = pending_q & mask_i;
  end

  assign wu_wfe_o    = wu_q;
  assign pending_o   = pending_q;
  assign busy_fall_o = busy_q & ~busy_i;

`ifdef REDMULE_EVT_CNT_EN
  logic [NumLines-1:0][15:0] evt_cnt_q, evt_cnt_d;

  // Counters saturate; a clear coinciding with an event restarts at 1.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    for (int j = 0; j < NumLines; j++) begin
      if (clr_i[j]) begin
        evt_cnt_d[j] = evt_i[j] ? 16'd1 : 16'd0;
      end else if (evt_i[j] && (evt_cnt_q[j] != 16'hFFFF)) begin
        evt_cnt_d[j] = evt_cnt_q[j] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) evt_cnt_q <= '0;
    else       evt_cnt_q <= evt_cnt_d;
  end

  assign evt_cnt_o = evt_cnt_q;
`endif

endmodule

// File: tb/tb_redmule_tile_evt_ctrl.sv
// Self-checking bench for redmule_tile_evt_ctrl: vector table, directed wake sequences,
// randomized run against a behavioural model. Counter checks when REDMULE_EVT_CNT_EN is defined.
module tb_redmule_tile_evt_ctrl;

  localparam int unsigned NCore = 1;
  localparam int unsigned NIrq  = 32;
  localparam int unsigned Base  = 16;
  localparam int unsigned Tmo   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  evt = '0, mask = '0, clr = '0;
  logic        sleep = 1'b0, busy = 1'b0;
  logic [31:0] irq;
  logic        wu, busy_fall;
  logic [1:0]  pend;
`ifdef REDMULE_EVT_CNT_EN
  logic [1:0][15:0] evt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  redmule_tile_evt_ctrl #(
    .N_CORE(NCore), .N_IRQ(NIrq), .EVT_IRQ_BASE(Base), .WAKE_TIMEOUT(Tmo)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .core_sleep_i(sleep),
    .busy_i      (busy),
    .mask_i      (mask),
    .clr_i       (clr),
    .irq_o       (irq),
    .wu_wfe_o    (wu),
    .pending_o   (pend),
`ifdef REDMULE_EVT_CNT_EN
    .evt_cnt_o   (evt_cnt),
`endif
    .busy_fall_o (busy_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    evt = '0; clr = '0; mask = '0; sleep = 1'b0; busy = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] evt, clr, mask;
    logic [1:0] exp_pend;
    logic [1:0] exp_irq;
  } vec_t;

  vec_t tbl[7];

  // Behavioural model state: pulse flag, cycles since last pulse (-1 when not waiting).
  logic [1:0] m_pend;
  bit         m_wu, m_armed, m_busy;
  int         m_age;
`ifdef REDMULE_EVT_CNT_EN
  int         m_cnt[2];
`endif

  task automatic model_step();
    bit wr;
    wr = |(m_pend & mask);
    if (m_wu) begin
      m_wu  = 0;
      m_age = 0;
    end else if (m_age >= 0) begin
      if (!sleep) m_age = -1;
      else if (m_age == Tmo - 1) begin
        m_age = -1;
        if (wr) m_wu = 1;
        else    m_armed = 1;
      end else m_age++;
    end else if (m_armed) begin
      if (!sleep) m_armed = 0;
      else if (wr) begin
        m_armed = 0;
        m_wu    = 1;
      end
    end else if (sleep) begin
      m_armed = 1;
    end
`ifdef REDMULE_EVT_CNT_EN
    for (int j = 0; j < 2; j++) begin
      if (clr[j]) m_cnt[j] = evt[j] ? 1 : 0;
      else if (evt[j] && m_cnt[j] < 65535) m_cnt[j]++;
    end
`endif
    m_pend = (m_pend & ~clr) | evt;
    m_busy = busy;
  endtask

  initial begin
    int first, pulses;
    logic [31:0] exp_irq;

    tbl[0] = '{evt: 2'b01, clr: 2'b00, mask: 2'b01, exp_pend: 2'b01, exp_irq: 2'b01};
    tbl[1] = '{evt: 2'b00, clr: 2'b01, mask: 2'b01, exp_pend: 2'b00, exp_irq: 2'b00};
    tbl[2] = '{evt: 2'b10, clr: 2'b00, mask: 2'b11, exp_pend: 2'b10, exp_irq: 2'b10};
    tbl[3] = '{evt: 2'b10, clr: 2'b10, mask: 2'b11, exp_pend: 2'b10, exp_irq: 2'b10};
    tbl[4] = '{evt: 2'b10, clr: 2'b00, mask: 2'b01, exp_pend: 2'b10, exp_irq: 2'b00};
    tbl[5] = '{evt: 2'b01, clr: 2'b11, mask: 2'b11, exp_pend: 2'b01, exp_irq: 2'b01};
    tbl[6] = '{evt: 2'b00, clr: 2'b01, mask: 2'b11, exp_pend: 2'b00, exp_irq: 2'b00};

    rst = 1'b1;
    #1;
    chk("rst_pend", 64'(pend), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_wu", 64'(wu), 64'd0);
    chk("rst_bfall", 64'(busy_fall), 64'd0);
    do_reset();

    // Pending/irq vectors, sleep low so no wake activity.
    for (int i = 0; i < 7; i++) begin
      evt = tbl[i].evt; clr = tbl[i].clr; mask = tbl[i].mask;
      step();
      exp_irq = 32'(tbl[i].exp_irq) << Base;
      chk($sformatf("vec%0d_pend", i), 64'(pend), 64'(tbl[i].exp_pend));
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'(exp_irq));
      chk($sformatf("vec%0d_wu", i), 64'(wu), 64'd0);
    end
    evt = '0; clr = '0;

    // Event while asleep: exactly one pulse, then sleep exit silences it.
    do_reset();
    sleep = 1'b1; mask = 2'b01;
    step(); step();
    evt = 2'b01;
    step();
    evt = 2'b00;
    chk("evt_wu_early", 64'(wu), 64'd0);
    step();
    chk("evt_wu_pulse", 64'(wu), 64'd1);
    step();
    chk("evt_wu_single", 64'(wu), 64'd0);
    step(); step();
    sleep = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (wu) pulses++;
    end
    chk("after_exit_pulses", 64'(pulses), 64'd0);

    // Pending already set when sleep rises: pulse two cycles after the rise.
    sleep = 1'b1;
    step();
    chk("rise_wu_armed", 64'(wu), 64'd0);
    step();
    chk("rise_wu_pulse", 64'(wu), 64'd1);

    // Timeout re-pulse.
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (wu && first < 0) first = i;
      if (first >= 0) break;
    end
    chk("timeout_gap", 64'(first), 64'd65);

    // Clear before timeout: no re-pulse, FSM waits armed.
    repeat (10) step();
    clr = 2'b01;
    step();
    clr = 2'b00;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wu) pulses++;
    end
    chk("cleared_pulses", 64'(pulses), 64'd0);
    evt = 2'b01;
    step();
    evt = 2'b00;
    chk("rearm_wu_early", 64'(wu), 64'd0);
    step();
    chk("rearm_wu_pulse", 64'(wu), 64'd1);

    // Async reset while pulsing.
    rst = 1'b1;
    #1;
    chk("rst_mid_wu", 64'(wu), 64'd0);
    chk("rst_mid_pend", 64'(pend), 64'd0);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    step();
    rst = 1'b0;
    sleep = 1'b0;

    // Busy falling edge.
    busy = 1'b1;
    step();
    chk("bfall_high", 64'(busy_fall), 64'd0);
    busy = 1'b0;
    #1;
    chk("bfall_pulse", 64'(busy_fall), 64'd1);
    step();
    chk("bfall_done", 64'(busy_fall), 64'd0);

    // Randomized run against the model.
    do_reset();
    m_pend = '0; m_wu = 0; m_armed = 0; m_busy = 0; m_age = -1;
`ifdef REDMULE_EVT_CNT_EN
    m_cnt[0] = 0; m_cnt[1] = 0;
`endif
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 1) sleep = ~sleep;
      if ($urandom_range(0, 29) == 0) mask = 2'($urandom);
      evt  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      clr  = ($urandom_range(0, 14) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 3) == 0) busy = ~busy;
      #1;
      exp_irq = 32'(m_pend & mask) << Base;
      chk("rnd_pend", 64'(pend), 64'(m_pend));
      chk("rnd_irq", 64'(irq), 64'(exp_irq));
      chk("rnd_wu", 64'(wu), 64'(m_wu));
      chk("rnd_bfall", 64'(busy_fall), 64'(m_busy & ~busy));
`ifdef REDMULE_EVT_CNT_EN
      chk("rnd_cnt0", 64'(evt_cnt[0]), 64'(m_cnt[0]));
      chk("rnd_cnt1", 64'(evt_cnt[1]), 64'(m_cnt[1]));
`endif
      @(posedge clk);
      model_step();
      #1;
    end
    evt = '0; clr = '0;

`ifdef REDMULE_EVT_CNT_EN
    do_reset();
    evt = 2'b01;
    repeat (70000) step();
    evt = 2'b00;
    chk("cnt_saturate", 64'(evt_cnt[0]), 64'hFFFF);
    chk("cnt_other", 64'(evt_cnt[1]), 64'd0);
    evt = 2'b01; clr = 2'b01;
    step();
    evt = 2'b00; clr = 2'b00;
    chk("cnt_clr_evt", 64'(evt_cnt[0]), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
